// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
// Turns the PS/2 set-2 scancode byte stream into key events.
// Prefix bytes E0 (extended) and F0 (break) are folded into a single event on
// the final byte of a sequence. The Pause sequence (E1 plus PAUSE_LEN bytes) is
// reported as one make of code E1. A partial sequence is abandoned after
// TIMEOUT idle cycles or on a receiver error.
//
// Optional feature: define KEY_REPEAT_FILTER_EN to suppress typematic repeats.
// A held-key register then remembers the last make, and identical makes are
// dropped until the matching break arrives. Pause is never filtered because it
// has no break code that could release it.
module ps2_key_decoder #(
  parameter logic [15:0] TIMEOUT   = 16'd50000,
  parameter logic [2:0]  PAUSE_LEN = 3'd7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_error,
  output logic [7:0] keycode,
  output logic       key_make,
  output logic       key_ext,
  output logic       key_valid
);

  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_E1 = 8'hE1;
  localparam logic [7:0] BYTE_F0 = 8'hF0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXT     = 3'd1,
    BRK     = 3'd2,
    EXT_BRK = 3'd3,
    PAUSE   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  state_t      w_eff_state;
  logic [15:0] r_tmo;
  logic [15:0] w_tmo_next;
  logic [2:0]  r_skip;
  logic [2:0]  w_skip_next;

  logic        w_is_prefix;
  logic        w_ignore;
  logic        w_restart;

  logic        w_evt;
  logic [7:0]  w_evt_code;
  logic        w_evt_make;
  logic        w_evt_ext;
  logic        w_report;

  // Byte classification and the effective state used to interpret this byte.
  // An unexpected prefix mid-sequence drops the partial sequence and the byte
  // is then handled exactly as if the machine had been idle.
  always_comb begin
    w_is_prefix = (rx_data == BYTE_E0) || (rx_data == BYTE_E1) ||
                  (rx_data == BYTE_F0);
    w_ignore    = (rx_data == 8'h00) || (rx_data == 8'hAA) ||
                  (rx_data == 8'hEE) || (rx_data == 8'hFA) ||
                  (rx_data == 8'hFC) || (rx_data == 8'hFE) ||
                  (rx_data == 8'hFF);
    w_restart   = w_is_prefix &&
                  (((r_state == EXT) && (rx_data != BYTE_F0)) ||
                   (r_state == BRK) || (r_state == EXT_BRK));
    w_eff_state = w_restart ? IDLE : r_state;
  end

  // Next-state, counter and event decode. Error beats a valid byte, and a
  // valid byte beats the timeout that would expire in the same cycle.
  always_comb begin
    w_state_next = r_state;
    w_skip_next  = r_skip;
    w_tmo_next   = (r_state == IDLE) ? 16'd0 : (r_tmo + 16'd1);
    w_evt        = 1'b0;
    w_evt_code   = rx_data;
    w_evt_make   = 1'b1;
    w_evt_ext    = 1'b0;

    if (rx_error) begin
      w_state_next = IDLE;
      w_skip_next  = 3'd0;
      w_tmo_next   = 16'd0;
    end else if (rx_valid) begin
      w_tmo_next   = 16'd0;
      w_state_next = IDLE;
      case (w_eff_state)
        IDLE: begin
          if (rx_data == BYTE_E0) begin
            w_state_next = EXT;
          end else if (rx_data == BYTE_F0) begin
            w_state_next = BRK;
          end else if (rx_data == BYTE_E1) begin
            w_state_next = PAUSE;
            w_skip_next  = PAUSE_LEN;
          end else if (!w_ignore) begin
            w_evt = 1'b1;
          end
        end
        EXT: begin
          if (rx_data == BYTE_F0) begin
            w_state_next = EXT_BRK;
          end else begin
            w_evt     = 1'b1;
            w_evt_ext = 1'b1;
          end
        end
        BRK: begin
          w_evt      = 1'b1;
          w_evt_make = 1'b0;
        end
        EXT_BRK: begin
          w_evt      = 1'b1;
          w_evt_make = 1'b0;
          w_evt_ext  = 1'b1;
        end
        PAUSE: begin
          // The last swallowed byte produces the single Pause event.
          if (r_skip <= 3'd1) begin
            w_evt       = 1'b1;
            w_evt_code  = BYTE_E1;
            w_skip_next = 3'd0;
          end else begin
            w_skip_next  = r_skip - 3'd1;
            w_state_next = PAUSE;
          end
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end else if ((r_state != IDLE) && (r_tmo == (TIMEOUT - 16'd1))) begin
      w_state_next = IDLE;
      w_skip_next  = 3'd0;
      w_tmo_next   = 16'd0;
    end
  end

`ifdef KEY_REPEAT_FILTER_EN
  logic [7:0] r_held_code;
  logic       r_held_ext;
  logic       r_held_valid;
  logic       w_held_hit;
  logic       w_filterable;

  // Decide whether a decoded event is a typematic repeat of the held key.
  always_comb begin
    w_filterable = (w_evt_code != BYTE_E1);
    w_held_hit   = r_held_valid && (r_held_code == w_evt_code) &&
                   (r_held_ext == w_evt_ext);
    w_report     = w_evt && !(w_filterable && w_evt_make && w_held_hit);
  end

  // Track the currently held key: load on a fresh make, release on its break.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_held_code  <= 8'h00;
      r_held_ext   <= 1'b0;
      r_held_valid <= 1'b0;
    end else if (w_evt && w_filterable) begin
      if (w_evt_make && !w_held_hit) begin
        r_held_code  <= w_evt_code;
        r_held_ext   <= w_evt_ext;
        r_held_valid <= 1'b1;
      end else if (!w_evt_make && w_held_hit) begin
        r_held_valid <= 1'b0;
      end
    end
  end
`else
  // Every decoded event is reported, typematic repeats included.
  assign w_report = w_evt;
`endif

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_tmo   <= 16'd0;
      r_skip  <= 3'd0;
    end else begin
      r_state <= w_state_next;
      r_tmo   <= w_tmo_next;
      r_skip  <= w_skip_next;
    end
  end

  // Registered event outputs: fields hold until the next reported event.
  always_ff @(posedge clk) begin
    if (reset) begin
      keycode   <= 8'h00;
      key_make  <= 1'b0;
      key_ext   <= 1'b0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= w_report;
      if (w_report) begin
        keycode  <= w_evt_code;
        key_make <= w_evt_make;
        key_ext  <= w_evt_ext;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder
// Directed scancode sequences followed by a random byte stream. A sequence
// model built on a queue of pending prefix bytes predicts each event and the
// cycle it must appear in; a monitor compares every key_valid pulse and checks
// that the output fields hold between events.
module tb_ps2_key_decoder;

  localparam int TMO  = 40;
  localparam int PLEN = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_error = 1'b0;
  logic [7:0] keycode;
  logic       key_make;
  logic       key_ext;
  logic       key_valid;

  ps2_key_decoder #(
    .TIMEOUT  (16'(TMO)),
    .PAUSE_LEN(3'(PLEN))
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_error (rx_error),
    .keycode  (keycode),
    .key_make (key_make),
    .key_ext  (key_ext),
    .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic       make;
    logic       ext;
    int         cyc;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] pend[$];
  int         idle_cnt = 0;
  int         cyc = 0;
  logic       rst_q = 1'b1;
  logic       done = 1'b0;
  int         tests = 0;
  int         fails = 0;
  logic       held_v = 1'b0;
  logic [7:0] held_c = 8'h00;
  logic       held_e = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  // ---------------- reference model ----------------
  function automatic void emit(logic [7:0] c, logic mk, logic ex, int cy);
    ev_t e;
`ifdef KEY_REPEAT_FILTER_EN
    if (c != 8'hE1) begin
      if (mk) begin
        if (held_v && held_c == c && held_e == ex) return;
        held_v = 1'b1;
        held_c = c;
        held_e = ex;
      end else if (held_v && held_c == c && held_e == ex) begin
        held_v = 1'b0;
      end
    end
`endif
    e.code = c;
    e.make = mk;
    e.ext  = ex;
    e.cyc  = cy;
    exp_q.push_back(e);
  endfunction

  function automatic void model_byte(logic [7:0] b, int cy);
    bit pre;
    pre = (b == 8'hE0) || (b == 8'hE1) || (b == 8'hF0);
    if (idle_cnt >= TMO && pend.size() != 0) pend.delete();
    if (pend.size() != 0 && pend[0] != 8'hE1 && pre &&
        !(pend.size() == 1 && pend[0] == 8'hE0 && b == 8'hF0))
      pend.delete();
    if (pend.size() == 0) begin
      if (pre) pend.push_back(b);
      else if (!(b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF}))
        emit(b, 1'b1, 1'b0, cy);
    end else if (pend[0] == 8'hE1) begin
      pend.push_back(b);
      if (pend.size() == PLEN + 1) begin
        emit(8'hE1, 1'b1, 1'b0, cy);
        pend.delete();
      end
    end else if (pend[pend.size()-1] == 8'hF0) begin
      emit(b, 1'b0, pend[0] == 8'hE0, cy);
      pend.delete();
    end else if (b == 8'hF0) begin
      pend.push_back(b);
    end else begin
      emit(b, 1'b1, 1'b1, cy);
      pend.delete();
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_error = 1'b0;
    rx_data  = b;
    model_byte(b, cyc + 1);
    idle_cnt = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_error = 1'b0;
      idle_cnt++;
    end
  endtask

  task automatic err(input logic with_valid, input logic [7:0] b);
    @(negedge clk);
    rx_error = 1'b1;
    rx_valid = with_valid;
    rx_data  = b;
    pend.delete();
    idle_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_error = 1'b0;
    pend.delete();
    idle_cnt = 0;
    held_v   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [7:0] hold_c = 8'h00;
  logic       hold_m = 1'b0;
  logic       hold_e = 1'b0;

  always @(negedge clk) begin
    ev_t e;
    if (rst_q) begin
      tests++;
      if (key_valid !== 1'b0 || keycode !== 8'h00 || key_make !== 1'b0 || key_ext !== 1'b0) begin
        fails++;
        $display("FAIL reset_state: got valid=%b code=%h make=%b ext=%b, expected all zero",
                 key_valid, keycode, key_make, key_ext);
      end
      hold_c = 8'h00;
      hold_m = 1'b0;
      hold_e = 1'b0;
    end else if (key_valid === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: got code=%h make=%b ext=%b cyc=%0d, expected no event",
                 keycode, key_make, key_ext, cyc);
      end else begin
        e = exp_q.pop_front();
        if (keycode !== e.code || key_make !== e.make || key_ext !== e.ext || cyc != e.cyc) begin
          fails++;
          $display("FAIL event: got code=%h make=%b ext=%b cyc=%0d, expected code=%h make=%b ext=%b cyc=%0d",
                   keycode, key_make, key_ext, cyc, e.code, e.make, e.ext, e.cyc);
        end else begin
          $display("[TB] event code=%h make=%0d ext=%0d cyc=%0d ok", keycode, key_make, key_ext, cyc);
        end
      end
      hold_c = keycode;
      hold_m = key_make;
      hold_e = key_ext;
    end else begin
      tests++;
      if (key_valid !== 1'b0 || keycode !== hold_c || key_make !== hold_m || key_ext !== hold_e) begin
        fails++;
        $display("FAIL hold: got valid=%b code=%h make=%b ext=%b, expected valid=0 code=%h make=%b ext=%b",
                 key_valid, keycode, key_make, key_ext, hold_c, hold_m, hold_e);
      end
    end

    if (done) begin
      tests++;
      if (exp_q.size() != 0) begin
        fails++;
        $display("FAIL missing_events: got %0d events outstanding, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end

    if (cyc > 90000) begin
      fails++;
      $display("FAIL watchdog: got cycle %0d, expected finish before 90000", cyc);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog expired");
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] codes[6]   = '{8'h1C, 8'h1D, 8'h29, 8'h75, 8'h12, 8'h6B};
  logic [7:0] ignores[7] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
  logic [7:0] pause_seq[8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

  function automatic logic [7:0] pick_byte();
    int r;
    r = $urandom_range(0, 19);
    if (r < 3)       return 8'hE0;
    else if (r < 6)  return 8'hF0;
    else if (r < 7)  return 8'hE1;
    else if (r < 9)  return ignores[$urandom_range(0, 6)];
    else if (r < 10) return 8'($urandom_range(0, 255));
    else             return codes[$urandom_range(0, 5)];
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // make then break
    send(8'h1D); send(8'hF0); send(8'h1D); idle(3);
    // extended make then extended break
    send(8'hE0); send(8'h75); idle(2);
    send(8'hE0); send(8'hF0); send(8'h75); idle(2);
    // timeout boundary: TMO idle cycles abandons E0, TMO-1 keeps it
    send(8'hE0); idle(TMO); send(8'h29); idle(2);
    send(8'hE0); idle(TMO - 1); send(8'h29); idle(2);
    send(8'hE0); send(8'hF0); idle(TMO); send(8'h29); idle(2);
    // error discards a pending break; error beats a simultaneous byte
    send(8'hF0); err(1'b0, 8'h00); send(8'h1B); idle(2);
    send(8'hF0); err(1'b1, 8'h1C); send(8'h1B); idle(2);
    // Pause sequence, then Pause interrupted by an error
    for (int i = 0; i < 8; i++) send(pause_seq[i]);
    idle(2);
    send(8'hE1); send(8'h14); err(1'b0, 8'h00); send(8'h77); idle(2);
    // typematic repeats
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); idle(2);
    // discarded bytes
    for (int i = 0; i < 7; i++) send(ignores[i]);
    idle(2);
    // unexpected prefixes restart the sequence
    send(8'hE0); send(8'hE0); send(8'h74); idle(1);
    send(8'hF0); send(8'hE0); send(8'hF0); send(8'h6B); idle(1);
    send(8'hF0); send(8'hF0); send(8'h12); idle(1);
    send(8'hE0); send(8'hF0); send(8'hE1);
    for (int i = 0; i < PLEN; i++) send(8'h33);
    idle(2);
    // reset mid-sequence
    send(8'hE0); do_reset(); send(8'h29); idle(2);

    // random stream
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4) err(1'($urandom_range(0, 1)), pick_byte());
      else if (r < 7) idle(TMO - 1 + $urandom_range(0, 1));
      else if (r < 8) do_reset();
      else begin
        send(pick_byte());
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    end

    idle(5);
    done = 1'b1;
  end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'd50000, giving the idle cycles allowed mid-sequence before the partial sequence is abandoned.
REQ-002 SHALL have parameter PAUSE_LEN, default 3'd7, giving the bytes following 0xE1 that are swallowed as the Pause sequence.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port rx_data, input, 8 bits: scancode byte from the PS/2 receiver.
REQ-006 SHALL have port rx_valid, input, 1 bit: a one-cycle strobe meaning rx_data is valid.
REQ-007 SHALL have port rx_error, input, 1 bit: a one-cycle strobe meaning a receiver parity or framing error.
REQ-008 SHALL have port keycode, output, 8 bits: the last reported key code, registered.
REQ-009 SHALL have port key_make, output, 1 bit: 1 means press and 0 means release for the last event, registered.
REQ-010 SHALL have port key_ext, output, 1 bit: 1 when the last event was E0-prefixed, registered.
REQ-011 SHALL have port key_valid, output, 1 bit: a one-cycle pulse on each new event.

Function
REQ-012 SHALL be a state machine with states IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen) and PAUSE (E1 seen).
REQ-013 SHALL act on a byte only in a cycle where rx_valid=1; all other cycles only advance the timeout counter.
REQ-014 SHALL, in IDLE, go to EXT on E0, BRK on F0 and PAUSE on E1 (loading the skip counter with PAUSE_LEN).
REQ-015 SHALL, in IDLE, silently discard 00, AA, EE, FA, FC, FE and FF.
REQ-016 SHALL, in IDLE, treat any other byte as a make with ext=0 and return to IDLE.
REQ-017 SHALL, in EXT, go to EXT_BRK on F0 and treat any other byte as a make with ext=1, then return to IDLE.
REQ-018 SHALL, in BRK, treat the next byte as a break with ext=0 and return to IDLE.
REQ-019 SHALL, in EXT_BRK, treat the next byte as a break with ext=1 and return to IDLE.
REQ-020 SHALL, in PAUSE, decrement the skip counter on each byte; on the byte that takes it to 0 it reports keycode=E1, make=1, ext=0 and returns to IDLE.
REQ-021 SHALL update keycode, key_make and key_ext and pulse key_valid on the clock edge that samples the final byte, so the event is visible one cycle after that rx_valid.
REQ-022 SHALL hold keycode, key_make and key_ext between events.
REQ-023 SHALL keep a 16-bit timeout counter that clears on every rx_valid and in IDLE, and otherwise increments.
REQ-024 SHALL, when the timeout counter reaches TIMEOUT-1 in any non-IDLE state, return to IDLE with no event.
REQ-025 SHALL, on rx_error, return to IDLE, clear the counters and report no event.
REQ-026 SHALL give rx_error priority over rx_valid in the same cycle.
REQ-027 SHALL, on an unexpected E0, E1 or F0 in EXT, BRK or EXT_BRK, abandon the partial sequence and reprocess that byte as if in IDLE.

Reset
REQ-028 SHALL, while reset=1, force state=IDLE, keycode=8'h00, key_make=0, key_ext=0, key_valid=0, both counters=0 and the held-key register invalid.
REQ-029 SHALL let reset override rx_valid and rx_error, discarding any partial sequence.

Configuration
REQ-030 SHALL, with macro KEY_REPEAT_FILTER_EN defined, keep a held-key register {code, ext, valid}.
REQ-031 SHALL, with KEY_REPEAT_FILTER_EN defined, suppress a make whose code and ext match the valid held key: no key_valid and outputs unchanged.
REQ-032 SHALL, with KEY_REPEAT_FILTER_EN defined, load any other make into the held-key register and invalidate it on a break whose code and ext match.
REQ-033 SHALL, without KEY_REPEAT_FILTER_EN, omit the held-key register and report every make, including typematic repeats.

Verification
REQ-034 SHALL cover: bytes 1D then F0 1D -> key_valid pulses giving {1D,make=1,ext=0} then {1D,make=0,ext=0}.
REQ-035 SHALL cover: bytes E0 75 then E0 F0 75 -> {75,1,1} then {75,0,1}, each pulse one cycle after the final byte.
REQ-036 SHALL cover: E0, then TIMEOUT idle cycles, then 29 -> no event for the E0, then {29,1,0}.
REQ-037 SHALL cover: F0 followed by rx_error, then 1B -> {1B,1,0}, i.e. the break is lost.
REQ-038 SHALL cover: the 8-byte Pause sequence E1 14 77 E1 F0 14 F0 77 -> exactly one event {E1,1,0}.
REQ-039 SHALL cover: 1C 1C 1C F0 1C -> filter on: two events (make, break); filter off: four events.
